naozhong_multi: RTL
===================

NAOZHONG_MULTI -- requirements
Module: naozhong_multi

Interface
REQ-001 SHALL have parameter N_ALM, default 4: number of alarm channels, range 1..8.
REQ-002 SHALL have parameter RING_SEC, default 60: ring timeout, in seconds.
REQ-003 SHALL have parameter SNOOZE_SEC, default 300: snooze interval, in seconds.
REQ-004 SHALL have parameter BEEP_CYC, default 25000: audio half-period, in clk cycles.
REQ-005 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port sec_tick  in  1  one-cycle pulse, once per second.
REQ-008 SHALL have port shi_date  in  8  current hour, BCD.
REQ-009 SHALL have port fen_date  in  8  current minute, BCD.
REQ-010 SHALL have port wr_en  in  1  alarm-time write strobe.
REQ-011 SHALL have port wr_idx  in  3  channel index for a write.
REQ-012 SHALL have port wr_shi  in  8  alarm hour to write, BCD.
REQ-013 SHALL have port wr_fen  in  8  alarm minute to write, BCD.
REQ-014 SHALL have port en_tgl  in  N_ALM  per-channel enable toggle, one-cycle pulses.
REQ-015 SHALL have port stop  in  1  one-cycle stop pulse.
REQ-016 SHALL have port snooze  in  1  one-cycle snooze pulse.
REQ-017 SHALL have port audio  out  1  buzzer drive.
REQ-018 SHALL have port alm_en  out  N_ALM  current per-channel enable flags.
REQ-019 SHALL have port ringing  out  1  high in state RING.
REQ-020 SHALL have port act_idx  out  3  channel that caused the current or last ring.

Function
REQ-021 SHALL store one {shi,fen} pair per channel.
REQ-022 SHALL write on wr_en with wr_idx<N_ALM; writes with wr_idx>=N_ALM are ignored; writes leave enables unchanged.
REQ-023 SHALL invert alm_en[i] on each cycle where en_tgl[i]=1; the new value is visible the next cycle.
REQ-024 SHALL compute match[i] = alm_en[i] & (shi_date==shi[i]) & (fen_date==fen[i]).
REQ-025 SHALL register match[i] each cycle as match_q[i] and define trig[i] = match[i] & ~match_q[i] (rising edge), so one matching minute triggers each channel at most once.
REQ-026 SHALL resolve simultaneous triggers to the lowest index, which is loaded into act_idx.
REQ-027 SHALL implement an FSM with states IDLE, RING and SNOOZE.
REQ-028 IDLE: any trig -> RING next cycle; ring counter cleared.
REQ-029 RING: stop -> IDLE; else snooze -> SNOOZE with snooze counter = SNOOZE_SEC; else RING_SEC sec_ticks counted -> IDLE (timeout).
REQ-030 RING: trig SHALL be ignored; act_idx is held.
REQ-031 SNOOZE: stop -> IDLE; else trig -> RING with new act_idx and ring counter cleared; else each sec_tick decrements the counter, and reaching 0 -> RING with ring counter cleared.
REQ-032 Priority in any state SHALL be stop > snooze > trig > timeout.
REQ-033 audio SHALL be 0 outside RING.
REQ-034 In RING, audio SHALL be a square wave that toggles every BEEP_CYC cycles, starting at 1 on the first RING cycle.
REQ-035 The tone divider SHALL restart on every entry to RING.
REQ-036 Counter widths SHALL be $clog2 of the corresponding parameter +1; no wrap-around is permitted.

Reset
REQ-037 rst_n low SHALL asynchronously force: FSM=IDLE, audio=0, ringing=0, act_idx=0, alm_en=0, all alarm times=8'h00, match_q=0, all counters=0.
REQ-038 Reset asserted mid-RING or mid-SNOOZE SHALL silence audio immediately; no state is retained.
REQ-039 After reset release, a current time already equal to an enabled alarm SHALL trigger only after that channel is enabled, via its edge (REQ-025).

Structure
REQ-040 State encoding and default parameter constants SHALL live in shared package naozhong_pkg.
REQ-041 The tone generator SHALL be sub-module naozhong_beep (clk, rst_n, run, audio).

Verification (N_ALM=4, RING_SEC=3, SNOOZE_SEC=2, BEEP_CYC=4)
REQ-042 Write ch1=07:30, toggle en ch1, time 07:29->07:30 -> ringing next cycle, act_idx=1, audio period 8 clk.
REQ-043 Ch0 and ch2 both set to 08:00 and enabled, time reaches 08:00 -> act_idx=0; a single ring only.
REQ-044 Ring with no input -> IDLE after 3 sec_ticks; time held at 07:30 -> no re-trigger.
REQ-045 snooze in RING -> SNOOZE, audio=0; 2 sec_ticks later -> RING again; stop and snooze on the same cycle -> IDLE.
REQ-046 Assert rst_n low mid-RING -> audio=0 asynchronously; alm_en=0 and alarm times=00:00 after release.
REQ-047 wr_idx=5 write -> no channel changes; en_tgl pulsed on ch3 twice -> alm_en[3]=0.

Source files
------------

// File: rtl/naozhong_pkg.sv
// Shared types and default constants for the multi-channel alarm clock.
package naozhong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } nz_state_e;

    // One stored alarm time, BCD hour and minute
    typedef struct packed {
        logic [7:0] shi;
        logic [7:0] fen;
    } nz_time_t;

    localparam int unsigned NZ_N_ALM      = 4;
    localparam int unsigned NZ_RING_SEC   = 60;
    localparam int unsigned NZ_SNOOZE_SEC = 300;
    localparam int unsigned NZ_BEEP_CYC   = 25000;
    localparam int unsigned NZ_IDX_W      = 3;

endpackage

// File: rtl/naozhong_beep.sv
// Square-wave tone generator: high for BEEP_CYC cycles, low for BEEP_CYC cycles,
// restarting high on the first cycle run is asserted after being low.
module naozhong_beep
    import naozhong_pkg::*;
#(
    parameter int unsigned BEEP_CYC = NZ_BEEP_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic audio
);

    localparam int unsigned CW = $clog2(BEEP_CYC) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          aud_q, aud_d;
    logic          act_q, act_d;

    // Phase counter and tone level; run must be the next-cycle RING indication
    always_comb begin
        cnt_d = cnt_q;
        aud_d = aud_q;
        act_d = act_q;
        if (!run) begin
            cnt_d = '0;
            aud_d = 1'b0;
            act_d = 1'b0;
        end else if (!act_q) begin
            cnt_d = CW'(1);
            aud_d = 1'b1;
            act_d = 1'b1;
        end else if (cnt_q == CW'(BEEP_CYC)) begin
            cnt_d = CW'(1);
            aud_d = ~aud_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Tone state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            aud_q <= 1'b0;
            act_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            aud_q <= aud_d;
            act_q <= act_d;
        end
    end

    assign audio = aud_q;

endmodule

// File: rtl/naozhong_multi.sv
// Multi-channel alarm: per-channel times and enables, edge-triggered match,
// ring/snooze/stop control and buzzer drive.
module naozhong_multi
    import naozhong_pkg::*;
#(
    parameter int unsigned N_ALM      = NZ_N_ALM,
    parameter int unsigned RING_SEC   = NZ_RING_SEC,
    parameter int unsigned SNOOZE_SEC = NZ_SNOOZE_SEC,
    parameter int unsigned BEEP_CYC   = NZ_BEEP_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sec_tick,
    input  logic [7:0]       shi_date,
    input  logic [7:0]       fen_date,
    input  logic             wr_en,
    input  logic [2:0]       wr_idx,
    input  logic [7:0]       wr_shi,
    input  logic [7:0]       wr_fen,
    input  logic [N_ALM-1:0] en_tgl,
    input  logic             stop,
    input  logic             snooze,
    output logic             audio,
    output logic [N_ALM-1:0] alm_en,
    output logic             ringing,
    output logic [2:0]       act_idx
);

    localparam int unsigned RW = $clog2(RING_SEC) + 1;
    localparam int unsigned SW = $clog2(SNOOZE_SEC) + 1;

    nz_time_t         alm_q [N_ALM];
    nz_time_t         alm_d [N_ALM];
    logic [N_ALM-1:0] alm_en_q, alm_en_d;
    logic [N_ALM-1:0] match_c, match_q, trig_c;
    logic             any_trig_c;
    logic [2:0]       trig_idx_c;

    nz_state_e        state_q, state_d;
    logic [RW-1:0]    ring_cnt_q, ring_cnt_d;
    logic [SW-1:0]    snz_cnt_q, snz_cnt_d;
    logic [2:0]       act_idx_q, act_idx_d;
    logic             ringing_q, ringing_d;
    logic             beep_run_c;

    // Alarm-time writes; indices outside the channel range match no channel
    always_comb begin
        for (int i = 0; i < int'(N_ALM); i++) begin
            alm_d[i] = alm_q[i];
            if (wr_en && (wr_idx == 3'(i))) begin
                alm_d[i].shi = wr_shi;
                alm_d[i].fen = wr_fen;
            end
        end
    end

    assign alm_en_d = alm_en_q ^ en_tgl;

    // Per-channel time match against the current clock
    always_comb begin
        match_c = '0;
        for (int i = 0; i < int'(N_ALM); i++) begin
            match_c[i] = alm_en_q[i] && (shi_date == alm_q[i].shi)
                                     && (fen_date == alm_q[i].fen);
        end
    end

    assign trig_c     = match_c & ~match_q;
    assign any_trig_c = |trig_c;

    // Lowest-index triggering channel wins
    always_comb begin
        trig_idx_c = '0;
        for (int i = int'(N_ALM) - 1; i >= 0; i--) begin
            if (trig_c[i]) begin
                trig_idx_c = 3'(i);
            end
        end
    end

    // Next-state logic; priority stop > snooze > trig > timeout
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        act_idx_d  = act_idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!stop && any_trig_c) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                    act_idx_d  = trig_idx_c;
                end
            end
            ST_RING: begin
                if (stop) begin
                    state_d    = ST_IDLE;
                    ring_cnt_d = '0;
                end else if (snooze) begin
                    state_d    = ST_SNOOZE;
                    ring_cnt_d = '0;
                    snz_cnt_d  = SW'(SNOOZE_SEC);
                end else if (sec_tick) begin
                    if (ring_cnt_q >= RW'(RING_SEC - 1)) begin
                        state_d    = ST_IDLE;
                        ring_cnt_d = '0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RW'(1);
                    end
                end
            end
            ST_SNOOZE: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    snz_cnt_d = '0;
                end else if (snooze) begin
                    snz_cnt_d = SW'(SNOOZE_SEC);
                end else if (any_trig_c) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                    snz_cnt_d  = '0;
                    act_idx_d  = trig_idx_c;
                end else if (sec_tick) begin
                    if (snz_cnt_q <= SW'(1)) begin
                        state_d    = ST_RING;
                        ring_cnt_d = '0;
                        snz_cnt_d  = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - SW'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ring_cnt_d = '0;
                snz_cnt_d  = '0;
            end
        endcase
    end

    assign ringing_d  = (state_d == ST_RING);
    assign beep_run_c = (state_d == ST_RING);

    // State, storage and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            act_idx_q  <= '0;
            ringing_q  <= 1'b0;
            alm_en_q   <= '0;
            match_q    <= '0;
            for (int i = 0; i < int'(N_ALM); i++) begin
                alm_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            act_idx_q  <= act_idx_d;
            ringing_q  <= ringing_d;
            alm_en_q   <= alm_en_d;
            match_q    <= match_c;
            for (int i = 0; i < int'(N_ALM); i++) begin
                alm_q[i] <= alm_d[i];
            end
        end
    end

    naozhong_beep #(
        .BEEP_CYC(BEEP_CYC)
    ) u_beep (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (beep_run_c),
        .audio(audio)
    );

    assign alm_en  = alm_en_q;
    assign ringing = ringing_q;
    assign act_idx = act_idx_q;

endmodule
